// File: rtl/rsa_modulo_product.sv
// rsa_modulo_product
//   Maps an operand into the Montgomery domain: m = a * 2^WIDTH mod N.
//   It performs one modular doubling per clock for WIDTH clocks. The
//   start/finish handshake matches the downstream Montgomery product stage.
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, sampled only while idle
//   N       : modulus, latched on accept
//   a       : operand, latched on accept (expected a < N)
//   m       : result, registered; held until the next result is written
//   finish  : one-cycle done pulse
//   busy    : high from accept until the cycle finish rises
//
// Timing (E0 = accept edge)
//   E1..E(WIDTH)  : doublings. The last doubling writes m and enters DONE.
//   E(WIDTH+1)    : DONE -> IDLE. finish_q rises and busy_q falls here.
//   finish is therefore high during the cycle after E0+WIDTH+1. With start
//   held high, the next accept happens on the edge that ends that cycle.

module rsa_modulo_product #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] m,
  output logic             finish,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;

  // One modular doubling of t. d carries one extra bit so the shifted-out
  // MSB still takes part in the compare. Because t < N, d < 2N, and the
  // difference always fits in WIDTH bits. The subtract can therefore run
  // on the low WIDTH bits only.
  logic [WIDTH:0]   dbl;
  logic             dbl_ge;
  logic [WIDTH-1:0] red;

  always_comb begin
    dbl    = {t_q, 1'b0};
    dbl_ge = (dbl >= {1'b0, n_q});
    red    = dbl_ge ? (dbl[WIDTH-1:0] - n_q) : dbl[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    t_d      = t_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    finish_d = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          n_d     = N;
          t_d     = a;
          cnt_d   = '0;
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        t_d    = red;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The final doubling goes straight into m. The counter stops here
          // and never wraps.
          m_d     = red;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      t_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      t_q      <= t_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign m      = m_q;
  assign finish = finish_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rsa_modulo_product.sv
// Bench for rsa_modulo_product.
// A 256-bit instance covers the directed full-width cases.
// An 8-bit instance covers the short-latency cases and the bulk random runs.
// Expected results come from plain modular arithmetic: (a << WIDTH) % N.

module tb_rsa_modulo_product;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         st256 = 1'b0;
  logic [255:0] n256 = '0, a256 = '0, m256;
  logic         fin256, busy256;

  logic         st8 = 1'b0;
  logic [7:0]   n8 = '0, a8 = '0, m8;
  logic         fin8, busy8;

  int total = 0;
  int bad   = 0;

  rsa_modulo_product #(.WIDTH(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(st256), .N(n256), .a(a256),
    .m(m256), .finish(fin256), .busy(busy256)
  );

  rsa_modulo_product #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .N(n8), .a(a8),
    .m(m8), .finish(fin8), .busy(busy8)
  );

  function automatic logic [255:0] ref256(input logic [255:0] n, input logic [255:0] av);
    logic [511:0] p, r;
    p = {av, 256'd0};
    r = p % {256'd0, n};
    return r[255:0];
  endfunction

  function automatic logic [7:0] ref8(input int n, input int av);
    int r;
    r = (av * 256) % n;
    return r[7:0];
  endfunction

  // Drives one request and measures it. lat counts the edges from the accept
  // edge to the first sample that shows finish high (-1 if none arrives).
  // bcnt counts the busy-high samples taken before that point.
  task automatic run256(input logic [255:0] n, input logic [255:0] av,
                        output logic [255:0] mo, output int lat, output int bcnt);
    mo = '0; lat = -1; bcnt = 0;
    @(negedge clk); n256 = n; a256 = av; st256 = 1'b1;
    @(posedge clk); #1;
    st256 = 1'b0;
    n256 = {8{$urandom}}; a256 = {8{$urandom}};  // must not affect the run
    if (busy256) bcnt++;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (fin256) begin lat = k; mo = m256; break; end
      if (busy256) bcnt++;
    end
  endtask

  task automatic run8(input logic [7:0] n, input logic [7:0] av,
                      output logic [7:0] mo, output int lat);
    mo = '0; lat = -1;
    @(negedge clk); n8 = n; a8 = av; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0; n8 = 8'($urandom); a8 = 8'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (fin8) begin lat = k; mo = m8; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (m256 !== 256'd0) begin bad++; $display("FAIL reset_m256 got=%h exp=0", m256); end
    total++; if (fin256 !== 1'b0 || busy256 !== 1'b0) begin bad++; $display("FAIL reset_ctl256 fin=%b busy=%b exp=0", fin256, busy256); end
    total++; if (m8 !== 8'd0 || fin8 !== 1'b0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_dut8 m=%h fin=%b busy=%b exp=0", m8, fin8, busy8); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_n13;
    logic [255:0] mo; int lat, bc;
    run256(256'd13, 256'd1, mo, lat, bc);
    total++; if (mo !== 256'd3) begin bad++; $display("FAIL n13_m got=%0d exp=3", mo); end
    total++; if (lat != 257) begin bad++; $display("FAIL n13_latency got=%0d exp=257", lat); end
    total++; if (bc != 257) begin bad++; $display("FAIL n13_busy_cycles got=%0d exp=257", bc); end
    total++; if (busy256 !== 1'b0) begin bad++; $display("FAIL n13_busy_at_finish got=%b exp=0", busy256); end
  endtask

  task automatic test_carry;
    logic [255:0] mo, n, av, ex; int lat, bc;
    n = '1; av = '1; av[0] = 1'b0; ex = av;
    run256(n, av, mo, lat, bc);
    total++; if (mo !== ex) begin bad++; $display("FAIL carry_m got=%h exp=%h", mo, ex); end
    total++; if (lat != 257) begin bad++; $display("FAIL carry_latency got=%0d exp=257", lat); end
  endtask

  task automatic test_small;
    logic [7:0] mo; int lat;
    run8(8'd251, 8'd5, mo, lat);
    total++; if (mo !== 8'd25) begin bad++; $display("FAIL w8_m got=%0d exp=25", mo); end
    total++; if (lat != 9) begin bad++; $display("FAIL w8_latency got=%0d exp=9", lat); end
    run8(8'd251, 8'd0, mo, lat);
    total++; if (mo !== 8'd0) begin bad++; $display("FAIL w8_zero got=%0d exp=0", mo); end
    run8(8'd0, 8'd77, mo, lat);   // undefined result, but it must still finish on time
    total++; if (lat != 9) begin bad++; $display("FAIL w8_n0_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_back_to_back;
    int nfin, k1, k2, kl; logic [7:0] m1, m2;
    nfin = 0; k1 = -1; k2 = -1; kl = -1; m1 = '0; m2 = '0;
    @(negedge clk); n8 = 8'd251; a8 = 8'd5; st8 = 1'b1;
    @(posedge clk); #1;
    n8 = 8'd241; a8 = 8'd7;       // picked up only by later accepts
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy8); end
      end
      if (fin8) begin
        nfin++; kl = k;
        if (nfin == 1) begin k1 = k; m1 = m8; end
        if (nfin == 2) begin k2 = k; m2 = m8; end
      end
    end
    st8 = 1'b0;
    total++; if (k1 != 9 || m1 !== 8'd25) begin bad++; $display("FAIL b2b_first k=%0d m=%0d exp k=9 m=25", k1, m1); end
    total++; if (k2 != 19 || m2 !== ref8(241, 7)) begin bad++; $display("FAIL b2b_second k=%0d m=%0d exp k=19 m=%0d", k2, m2, ref8(241, 7)); end
    total++; if (nfin != 4 || kl != 39) begin bad++; $display("FAIL b2b_count got=%0d last=%0d exp=4 last=39", nfin, kl); end
    repeat (15) @(posedge clk);   // let the run accepted at edge 40 drain
  endtask

  task automatic test_reset_mid;
    logic [255:0] mo; int lat, bc, nf;
    @(negedge clk); n256 = 256'd13; a256 = 256'd1; st256 = 1'b1;
    @(posedge clk); #1; st256 = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    total++; if (busy256 !== 1'b1 || m256 === 256'd0) begin bad++; $display("FAIL rmid_pre busy=%b m=%h exp busy=1 m!=0", busy256, m256); end
    rst_n = 1'b0;
    #1;
    total++; if (m256 !== 256'd0 || fin256 !== 1'b0 || busy256 !== 1'b0) begin
      bad++; $display("FAIL rmid_async m=%h fin=%b busy=%b exp=0", m256, fin256, busy256); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nf = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (fin256 || busy256) nf++;
    end
    total++; if (nf != 0) begin bad++; $display("FAIL rmid_no_finish got=%0d exp=0", nf); end
    run256(256'd13, 256'd1, mo, lat, bc);
    total++; if (mo !== 256'd3 || lat != 257) begin bad++; $display("FAIL rmid_rerun m=%0d lat=%0d exp m=3 lat=257", mo, lat); end
  endtask

  task automatic test_random8;
    logic [7:0] mo, n, av; int lat;
    for (int i = 0; i < 1000; i++) begin
      n = 8'($urandom_range(1, 127) * 2 + 1);
      av = 8'($urandom % n);
      run8(n, av, mo, lat);
      total++; if (mo !== ref8(n, av) || lat != 9) begin
        bad++; $display("FAIL rnd8 n=%0d a=%0d m=%0d lat=%0d exp m=%0d lat=9", n, av, mo, lat, ref8(n, av)); end
      repeat (2) @(posedge clk); #1;
      total++; if (m8 !== mo) begin bad++; $display("FAIL rnd8_hold got=%0d exp=%0d", m8, mo); end
    end
  endtask

  task automatic test_random256;
    logic [255:0] mo, n, av, r; int lat, bc;
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < 8; w++) begin
        n[w*32 +: 32] = $urandom;
        r[w*32 +: 32] = $urandom;
      end
      n[0] = 1'b1;
      if (n <= 256'd1) n = 256'd3;
      av = r % n;
      run256(n, av, mo, lat, bc);
      total++; if (mo !== ref256(n, av) || lat != 257) begin
        bad++; $display("FAIL rnd256 m=%h exp=%h lat=%0d", mo, ref256(n, av), lat); end
    end
  endtask

  initial begin
    test_reset;
    test_n13;
    test_carry;
    test_small;
    test_back_to_back;
    test_reset_mid;
    test_random8;
    test_random256;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
